// File: rtl/encoder83_pkg.sv
// encoder83_pkg: definitions shared by the 8-to-3 encoder block.
//   IN_W / IDX_W : width of the source word and of the encoded index.
//   state_t      : output-stage occupancy (EMPTY, FULL).
//   result_t     : encoded index plus the illegal-word flag.
// Optional build macro: ENCODER83_PRIORITY_EN (multi-hot words encode
// to the highest set bit instead of being flagged).
package encoder83_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
  } result_t;

  // Result used for every word that cannot be encoded as-is.
  localparam result_t RESULT_ERR = '{idx: '0, err: 1'b1};

endpackage

// File: rtl/encoder83_core.sv
// encoder83_core: purely combinational map from a source word to result_t.
//   in_code : source word, bit k stands for value k
//   res     : {idx, err}
// Policy:
//   zero word        -> idx 0, err 1
//   single bit k     -> idx k, err 0
//   two or more bits -> ENCODER83_PRIORITY_EN defined : idx = highest bit, err 0
//                       ENCODER83_PRIORITY_EN undefined: idx 0, err 1
module encoder83_core
  import encoder83_pkg::*;
(
  input  logic [IN_W-1:0] in_code,
  output result_t         res
);

  logic [3:0]       ones;
  logic [IDX_W-1:0] hi;

  // Population count and index of the highest set bit. Scanning upward
  // lets later (higher) bits overwrite hi, so it ends on the top one.
  always_comb begin
    ones = '0;
    hi   = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_code[i]) begin
        ones = ones + 4'd1;
        hi   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    res = RESULT_ERR;
    if (ones == 4'd1) begin
      res = '{idx: hi, err: 1'b0};
    end else if (ones > 4'd1) begin
`ifdef ENCODER83_PRIORITY_EN
      res = '{idx: hi, err: 1'b0};
`else
      res = RESULT_ERR;
`endif
    end
  end

endmodule

// File: rtl/encoder83.sv
// encoder83: registered 8-to-3 encoder with a one-entry output stage and
// a saturating count of flagged words.
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   en                   : enable; low stops new words being accepted
//   in_valid, in_ready   : input handshake, in_code is the source word
//   out_valid, out_ready : output handshake, out_idx/out_err is the result
//   err_cnt              : accepted words flagged out_err, saturates at all-ones
//   dbg_state            : current output-stage state, for observation
// Optional build macro: ENCODER83_PRIORITY_EN (see encoder83_core).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready = en & (!out_valid | out_ready), so it depends
// combinationally on out_ready; a held result stays stable until taken.
module encoder83
  import encoder83_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_code,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output state_t           dbg_state
);

  state_t  state_q, state_d;
  result_t res_q;
  result_t core_res;
  logic    accept;

  encoder83_core u_core (
    .in_code (in_code),
    .res     (core_res)
  );

  assign out_valid = (state_q == FULL);
  assign in_ready  = en & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_idx   = res_q.idx;
  assign out_err   = res_q.err;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      // Accepting while FULL implies out_ready, so the slot is refilled.
      FULL:  if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Result register only loads on acceptance, which keeps it stable while
  // the downstream stalls (acceptance is impossible then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (accept) begin
      res_q <= core_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && core_res.err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_encoder83.sv
module tb_encoder83;
  import encoder83_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] in_code;
  logic       out_ready;

  logic       in_ready,  in_ready2;
  logic       out_valid, out_valid2;
  logic [2:0] out_idx,   out_idx2;
  logic       out_err,   out_err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  state_t     dbg_state, dbg_state2;

  int checks   = 0;
  int failures = 0;

  // Expected results, {idx, err}
  logic [3:0] exp_q[$];
  logic       model_full;
  int         exp_cnt8;
  int         exp_cnt2;

  encoder83 #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_err(out_err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  encoder83 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_idx(out_idx2), .out_err(out_err2), .err_cnt(err_cnt2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: from the word's bit count and its highest set bit.
  function automatic logic [3:0] ref_encode(input logic [7:0] c);
    int n;
    int hi;
    n = $countones(c);
    if (n == 0) return 4'b0001;
    hi = $clog2(int'(c) + 1) - 1;
    if (n == 1) return {hi[2:0], 1'b0};
`ifdef ENCODER83_PRIORITY_EN
    return {hi[2:0], 1'b0};
`else
    return 4'b0001;
`endif
  endfunction

  // Issue tracker: pushes the expected result of every accepted word.
  always @(posedge clk or negedge rst_n) begin
    logic       acc;
    logic [3:0] r;
    if (!rst_n) begin
      exp_q.delete();
      model_full = 1'b0;
      exp_cnt8   = 0;
      exp_cnt2   = 0;
    end else begin
      acc = in_valid && en && (!model_full || out_ready);
      if (acc) begin
        r = ref_encode(in_code);
        exp_q.push_back(r);
        if (r[0]) begin
          if (exp_cnt8 < 255) exp_cnt8++;
          if (exp_cnt2 < 3)   exp_cnt2++;
        end
      end
      model_full = acc || (model_full && !out_ready);
    end
  end

  // Monitor: compares presented outputs, pops when the result is taken.
  always @(negedge clk) begin
    logic full;
    if (rst_n) begin
      full = (exp_q.size() != 0);
      chk("out_valid", int'(out_valid), int'(full));
      chk("out_valid2", int'(out_valid2), int'(full));
      chk("in_ready", int'(in_ready), int'(en && (!full || out_ready)));
      chk("in_ready2", int'(in_ready2), int'(en && (!full || out_ready)));
      chk("dbg_state", int'(dbg_state), full ? int'(FULL) : int'(EMPTY));
      chk("err_cnt", int'(err_cnt), exp_cnt8);
      chk("err_cnt2", int'(err_cnt2), exp_cnt2);
      if (full) begin
        chk("out_idx", int'(out_idx), int'(exp_q[0][3:1]));
        chk("out_err", int'(out_err), int'(exp_q[0][0]));
        chk("out_idx2", int'(out_idx2), int'(exp_q[0][3:1]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver: hold values through the next rising edge
  task automatic step(input logic e, input logic v, input logic [7:0] c, input logic r);
    en = e; in_valid = v; in_code = c; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] c;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // one-hot sweep at full throughput
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 8'h01 << k, 1'b1);
    idle();
    // zero word and multi-hot word
    step(1'b1, 1'b1, 8'h00, 1'b1); idle();
    step(1'b1, 1'b1, 8'h28, 1'b1); idle();
    // backpressure: result held, new word waits
    step(1'b1, 1'b1, 8'h04, 1'b1);
    repeat (3) step(1'b1, 1'b1, 8'h10, 1'b0);
    step(1'b1, 1'b1, 8'h10, 1'b1);
    idle();
    // enable low blocks acceptance
    repeat (3) step(1'b0, 1'b1, 8'h40, 1'b1);
    step(1'b1, 1'b1, 8'h40, 1'b1);
    idle();
    // en dropped while FULL: result still held then drained
    step(1'b1, 1'b1, 8'h08, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b1);
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       c = 8'h00;
        1, 2:    c = 8'h01 << $urandom_range(0, 7);
        default: c = 8'($urandom);
      endcase
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, c,
           $urandom_range(0, 3) != 0);
    end
    idle(); idle();

    // asynchronous reset while FULL
    step(1'b1, 1'b1, 8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_err_cnt", int'(err_cnt), 0);
    chk("async_err_cnt2", int'(err_cnt2), 0);
    chk("async_out_idx", int'(out_idx), 0);
    chk("async_state", int'(dbg_state), int'(EMPTY));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // saturation of the narrow counter
    repeat (5) step(1'b1, 1'b1, 8'h00, 1'b1);
    idle();
    chk("sat_err_cnt2", int'(err_cnt2), 3);
    chk("sat_err_cnt", int'(err_cnt), 5);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
